// File: rtl/poly_decompress_unpack.sv
// rtl/poly_decompress_unpack.sv - streaming Kyber ByteDecode_D + Decompress_D for one 256-coefficient polynomial
module poly_decompress_unpack #(
    parameter int Q = 3329,
    parameter int N = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  d_sel,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_coeff,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  d_q, d_d;
    logic [8:0]  bytes_left_q, bytes_left_d;
    logic [8:0]  coeff_cnt_q, coeff_cnt_d;
    logic [17:0] buf_q, buf_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [11:0] out_coeff_q, out_coeff_d;
    logic        err_q, err_d;

    logic        d_legal;
    logic        acc;
    logic        ext;
    logic        out_hs;
    logic [4:0]  shift_amt;
    logic [4:0]  land_pos;
    logic [17:0] shifted;
    logic [17:0] merged;
    logic [10:0] y_mask;
    logic [10:0] y;
    logic [22:0] prod;

    // Byte acceptance looks only at registered occupancy, so a full buffer
    // never depends on whether an extraction happens in the same cycle.
    assign in_ready  = (state_q == RUN) && (bytes_left_q != 9'd0) && (bit_cnt_q <= 5'd10);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_coeff = out_coeff_q;
    assign err       = err_q;

    // Datapath helpers: extraction/accept qualifiers, buffer merge, rounding multiply.
    always_comb begin
        d_legal   = (d_sel == 4'd1) || (d_sel == 4'd4) || (d_sel == 4'd5) ||
                    (d_sel == 4'd10) || (d_sel == 4'd11);
        acc       = in_valid && in_ready;
        out_hs    = out_valid_q && out_ready;
        ext       = (state_q == RUN) && (bit_cnt_q >= {1'b0, d_q}) &&
                    (coeff_cnt_q < 9'(N)) && (!out_valid_q || out_ready);
        shift_amt = ext ? {1'b0, d_q} : 5'd0;
        shifted   = buf_q >> shift_amt;
        // The new byte sits directly above the bits that survive this cycle's shift.
        land_pos  = bit_cnt_q - shift_amt;
        merged    = shifted | ({10'b0, in_data} << land_pos);
        y_mask    = (11'd1 << d_q) - 11'd1;
        y         = buf_q[10:0] & y_mask;
        // Round-half-up of Q*y/2^D; the result never exceeds Q-1.
        prod      = 23'(Q) * {12'b0, y} + (23'd1 << (d_q - 4'd1));
    end

    // Next-state and register updates for control, buffer and output stage.
    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        bytes_left_d = bytes_left_q;
        coeff_cnt_d  = coeff_cnt_q;
        buf_d        = buf_q;
        bit_cnt_d    = bit_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_coeff_d  = out_coeff_q;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (d_legal) begin
                        d_d          = d_sel;
                        bytes_left_d = {d_sel, 5'b0};
                        coeff_cnt_d  = 9'd0;
                        buf_d        = 18'd0;
                        bit_cnt_d    = 5'd0;
                        state_d      = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                buf_d     = acc ? merged : shifted;
                bit_cnt_d = bit_cnt_q + (acc ? 5'd8 : 5'd0) - shift_amt;
                if (acc) begin
                    bytes_left_d = bytes_left_q - 9'd1;
                end
                if (ext) begin
                    coeff_cnt_d = coeff_cnt_q + 9'd1;
                    if (coeff_cnt_q == 9'(N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_hs && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output register holds its value until consumed; a new extraction
        // only happens when it is free or being consumed this cycle.
        if (ext) begin
            out_valid_d = 1'b1;
            out_coeff_d = 12'(prod >> d_q);
            out_last_d  = (coeff_cnt_q == 9'(N - 1));
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // State register with asynchronous reset; a reset discards any partial polynomial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            d_q          <= 4'd0;
            bytes_left_q <= 9'd0;
            coeff_cnt_q  <= 9'd0;
            buf_q        <= 18'd0;
            bit_cnt_q    <= 5'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_coeff_q  <= 12'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            bytes_left_q <= bytes_left_d;
            coeff_cnt_q  <= coeff_cnt_d;
            buf_q        <= buf_d;
            bit_cnt_q    <= bit_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_coeff_q  <= out_coeff_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_poly_decompress_unpack.sv
// tb/tb_poly_decompress_unpack.sv - self-checking bench for poly_decompress_unpack
module tb_poly_decompress_unpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  d_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_coeff;
    logic        out_last;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [7:0] stim[$];
    int exp_c[256];
    int got_c[256];
    int run_cyc, run_gap, run_ir_high;

    poly_decompress_unpack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .d_sel     (d_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: read D-bit little-endian fields from the byte stream and round Q*y/2^D.
    function automatic void build_expected(input int d);
        for (int i = 0; i < 256; i++) begin
            int y;
            y = 0;
            for (int b = 0; b < d; b++) begin
                int p;
                logic [7:0] byt;
                p = i * d + b;
                byt = stim[p / 8];
                if (byt[p % 8]) y += (1 << b);
            end
            exp_c[i] = (3329 * y + (1 << (d - 1))) / (1 << d);
        end
    endfunction

    task automatic fill_const(input int d, input logic [7:0] v);
        stim.delete();
        for (int i = 0; i < 32 * d; i++) stim.push_back(v);
    endtask

    task automatic fill_rand(input int d);
        stim.delete();
        for (int i = 0; i < 32 * d; i++) stim.push_back(8'($urandom));
    endtask

    // Drive one polynomial; bench-side occupancy counters predict in_ready/out_valid.
    task automatic run_poly(input int d, input int in_pct, input int out_pct,
                            input bit start_mid, input string name);
        int  macc, mext, mbits, hs, cyc;
        bit  mov, m_acc, m_ext, exp_ir, prev_stall, seen;
        int  ir_bad, ov_bad, val_bad, last_bad, stab_bad, gap, ir_high;
        logic [11:0] prev_coeff;
        macc = 0; mext = 0; mbits = 0; hs = 0; cyc = 0; mov = 0;
        ir_bad = 0; ov_bad = 0; val_bad = 0; last_bad = 0; stab_bad = 0;
        gap = 0; ir_high = 0; prev_stall = 0; seen = 0; prev_coeff = 12'd0;
        build_expected(d);
        @(negedge clk);
        d_sel = 4'(d); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL %s busy_rise: got %0b want 1", name, busy);
        end
        while (hs < 256 && cyc < 6000) begin
            cyc++;
            start = start_mid && (cyc == 40);
            if (start) d_sel = 4'd1;
            in_valid  = (macc < stim.size()) && ($urandom_range(99) < in_pct);
            in_data   = in_valid ? stim[macc] : 8'($urandom);
            out_ready = ($urandom_range(99) < out_pct);
            exp_ir = (macc < 32 * d) && (mbits <= 10);
            if (in_ready !== exp_ir) ir_bad++;
            if (out_valid !== mov) ov_bad++;
            if (in_ready === 1'b1) ir_high++;
            if (seen && out_valid !== 1'b1) gap++;
            if (mov) seen = 1;
            if (prev_stall && (out_valid !== 1'b1 || out_coeff !== prev_coeff)) stab_bad++;
            if (mov && out_ready) begin
                got_c[hs] = int'(out_coeff);
                if (out_coeff !== 12'(exp_c[hs])) begin
                    val_bad++;
                    if (val_bad <= 3)
                        $display("FAIL %s coeff[%0d]: got %0d want %0d", name, hs, out_coeff, exp_c[hs]);
                end
                if (out_last !== (hs == 255)) last_bad++;
                hs++;
            end
            m_acc = in_valid && exp_ir;
            m_ext = (mbits >= d) && (mext < 256) && (!mov || out_ready);
            mbits = mbits + (m_acc ? 8 : 0) - (m_ext ? d : 0);
            if (m_acc) macc++;
            if (m_ext) mext++;
            mov = m_ext ? 1'b1 : ((mov && out_ready) ? 1'b0 : mov);
            prev_stall = mov && !out_ready && !m_ext ? 1'b0 : 1'b0;
            prev_stall = out_valid && !out_ready;
            prev_coeff = out_coeff;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        tests++;
        if (hs != 256) begin
            fails++; $display("FAIL %s timeout: got %0d coeffs want 256", name, hs);
        end
        tests++;
        if (val_bad != 0) begin
            fails++; $display("FAIL %s values: got %0d bad want 0", name, val_bad);
        end
        tests++;
        if (last_bad != 0) begin
            fails++; $display("FAIL %s out_last: got %0d bad want 0", name, last_bad);
        end
        tests++;
        if (ir_bad != 0) begin
            fails++; $display("FAIL %s in_ready: got %0d bad cycles want 0", name, ir_bad);
        end
        tests++;
        if (ov_bad != 0) begin
            fails++; $display("FAIL %s out_valid: got %0d bad cycles want 0", name, ov_bad);
        end
        tests++;
        if (stab_bad != 0) begin
            fails++; $display("FAIL %s stall_hold: got %0d bad want 0", name, stab_bad);
        end
        tests++;
        if (macc != 32 * d) begin
            fails++; $display("FAIL %s bytes: got %0d want %0d", name, macc, 32 * d);
        end
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL %s end_idle: got busy=%0b ov=%0b want 0 0", name, busy, out_valid);
        end
        run_cyc = cyc; run_gap = gap; run_ir_high = ir_high;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; d_sel = 4'd0; in_valid = 1'b0;
        in_data = 8'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, out_last, busy, err, out_coeff} !== 17'd0) begin
            fails++;
            $display("FAIL reset_state: got %0h want 0", {in_ready, out_valid, out_last, busy, err, out_coeff});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_d4_plan();
        stim.delete();
        stim.push_back(8'hA5);
        for (int i = 1; i < 128; i++) stim.push_back(8'h00);
        run_poly(4, 100, 100, 1'b0, "d4_plan");
        tests++;
        if (got_c[0] != 1040 || got_c[1] != 2081 || got_c[2] != 0 || got_c[255] != 0) begin
            fails++;
            $display("FAIL d4_plan_consts: got %0d %0d %0d want 1040 2081 0", got_c[0], got_c[1], got_c[2]);
        end
    endtask

    task automatic test_d1_plan();
        int n1665;
        fill_const(1, 8'hFF);
        run_poly(1, 100, 100, 1'b0, "d1_plan");
        n1665 = 0;
        for (int i = 0; i < 256; i++) if (got_c[i] == 1665) n1665++;
        tests++;
        if (n1665 != 256) begin
            fails++; $display("FAIL d1_consts: got %0d of 1665 want 256", n1665);
        end
        tests++;
        if (run_gap != 0) begin
            fails++; $display("FAIL d1_continuous: got %0d gaps want 0", run_gap);
        end
        tests++;
        if (run_ir_high * 8 > run_cyc + 8) begin
            fails++; $display("FAIL d1_in_ready_duty: got %0d of %0d cycles", run_ir_high, run_cyc);
        end
    endtask

    task automatic test_d10_d11_plan();
        int n3327;
        stim.delete();
        stim.push_back(8'hFF);
        stim.push_back(8'h03);
        for (int i = 2; i < 320; i++) stim.push_back(8'h00);
        run_poly(10, 100, 100, 1'b0, "d10_plan");
        tests++;
        if (got_c[0] != 3326 || got_c[1] != 0) begin
            fails++; $display("FAIL d10_consts: got %0d %0d want 3326 0", got_c[0], got_c[1]);
        end
        fill_const(11, 8'hFF);
        run_poly(11, 100, 100, 1'b0, "d11_plan");
        n3327 = 0;
        for (int i = 0; i < 256; i++) if (got_c[i] == 3327) n3327++;
        tests++;
        if (n3327 != 256) begin
            fails++; $display("FAIL d11_consts: got %0d of 3327 want 256", n3327);
        end
    endtask

    task automatic test_d5_backpressure();
        int n3225;
        fill_const(5, 8'hFF);
        run_poly(5, 60, 45, 1'b0, "d5_bp");
        n3225 = 0;
        for (int i = 0; i < 256; i++) if (got_c[i] == 3225) n3225++;
        tests++;
        if (n3225 != 256) begin
            fails++; $display("FAIL d5_consts: got %0d of 3225 want 256", n3225);
        end
    endtask

    task automatic test_random();
        int ds[5] = '{1, 4, 5, 10, 11};
        for (int k = 0; k < 5; k++) begin
            fill_rand(ds[k]);
            run_poly(ds[k], 30 + 14 * k, 85 - 12 * k, 1'b0, $sformatf("rand_d%0d", ds[k]));
        end
    endtask

    task automatic test_start_in_run();
        fill_rand(4);
        run_poly(4, 70, 70, 1'b1, "start_in_run");
    endtask

    task automatic test_illegal();
        int pulses;
        @(negedge clk);
        d_sel = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL illegal_err: got err=%0b busy=%0b rdy=%0b want 1 0 0", err, busy, in_ready);
        end
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (err !== 1'b0 || busy !== 1'b0) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++; $display("FAIL illegal_single_pulse: got %0d extra cycles want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        fill_const(4, 8'hFF);
        @(negedge clk);
        d_sel = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL mid_active: got ov=%0b busy=%0b want 1 1", out_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, out_last, busy, err, out_coeff} !== 17'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %0h want 0", {in_ready, out_valid, out_last, busy, err, out_coeff});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fill_rand(4);
        run_poly(4, 80, 80, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_d4_plan();
        test_d1_plan();
        test_d10_d11_plan();
        test_d5_backpressure();
        test_random();
        test_start_in_run();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
